bp_me_mem_stream_arbiter: RTL and testbench
===========================================

# bp_me_mem_stream_arbiter

Two-requester arbiter that shares one BedRock stream memory port (mem_cmd/mem_resp with header, data, v, ready_and, last) between two cache engines, e.g. the I$ UCE and the D$ UCE feeding a single bp_nonsynth_mem or L2 port. Commands are granted whole-packet (first beat through last beat) with round-robin fairness. Responses, returned in order by memory, are steered back to the originating requester using an in-order ID FIFO.

## Interface
Parameters:
- header_width_p, 64: BedRock mem header width (bits).
- data_width_p, 64: stream beat width (l2_fill_width_p).
- max_outstanding_p, 4: max command packets accepted whose response packet has not fully returned; ≥1.

Ports (index [i] = requester 0/1; per-requester buses packed [1:0]):
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-low.
- req_cmd_header_i[i]  in  header_width_p  requester command header.
- req_cmd_data_i[i]  in  data_width_p  requester command beat.
- req_cmd_v_i[i]  in  1  command beat valid.
- req_cmd_ready_and_o[i]  out  1  command beat accepted when v&ready_and.
- req_cmd_last_i[i]  in  1  final beat of command packet.
- req_resp_header_o[i], req_resp_data_o[i], req_resp_v_o[i], req_resp_last_o[i]  out  header/data/1/1  routed response.
- req_resp_ready_and_i[i]  in  1  requester accepts response beat.
- mem_cmd_header_o, mem_cmd_data_o, mem_cmd_v_o, mem_cmd_last_o  out  header/data/1/1  merged command stream.
- mem_cmd_ready_and_i  in  1  memory accepts command beat.
- mem_resp_header_i, mem_resp_data_i, mem_resp_v_i, mem_resp_last_i  in  header/data/1/1  memory response stream.
- mem_resp_ready_and_o  out  1  response beat accepted.

## Operation
- Command FSM states: IDLE, LOCK0, LOCK1. Reset → IDLE.
- IDLE: candidate set = requesters with req_cmd_v_i=1; if ID FIFO full, no candidate. One candidate wins directly; two candidates → winner is the one ≠ rr_last (rr_last resets to 1, so requester 0 wins first tie).
- Winner's beat drives mem_cmd_*; mem_cmd_v_o=1; req_cmd_ready_and_o[winner]=mem_cmd_ready_and_i; loser ready_and=0.
- On first-beat handshake: push winner ID into ID FIFO; rr_last←winner. If last=0 → LOCK<winner>; if last=1 → stay IDLE.
- LOCKn: only requester n forwarded (no FIFO-full check); other requester ready_and=0. Handshake with last=1 → IDLE.
- Header on non-first beats is forwarded unchanged; arbiter does not inspect header contents.
- Response path: head = ID FIFO head. If FIFO non-empty: req_resp_v_o[head]=mem_resp_v_i, mem_resp_ready_and_o=req_resp_ready_and_i[head]; other requester v=0. Handshake with mem_resp_last_i=1 pops FIFO.
- FIFO empty: mem_resp_ready_and_o=0, all req_resp_v_o=0 (stray response stalls; never dropped).
- Response headers/data fan out to both requesters unconditionally; only v is gated.
- ID FIFO: depth max_outstanding_p, 1-bit entries, count width $clog2(max_outstanding_p+1); pointers wrap modulo depth.

## Timing
- Command and response paths are combinational pass-through: 0-cycle latency, no bubbles between beats or packets (back-to-back packets from alternating requesters at full rate).
- FSM, rr_last, FIFO updated on clk_i posedge; FIFO push visible to response path next cycle (memory must not respond in the same cycle as first command beat).
- Full check uses registered count: simultaneous pop at full does not enable a push that cycle.
- Simultaneous push and pop at non-full, non-empty: count unchanged.
- Reset (any time, including mid-packet): state IDLE, rr_last=1, FIFO empty; all outputs v/ready_and=0 while reset_i=0. Partial packets are abandoned; memory and requesters must be reset together.

## Configuration
- BP_ME_MEM_ARB_FIXED_PRIO_EN defined: IDLE tie-break always selects requester 0 (rr_last ignored, still updated); requester 1 may starve.
- Undefined (default): round-robin tie-break as above.

## Test plan
- Single packet: req0 sends 2-beat cmd (last on beat 2), mem ready → mem_cmd sees 2 beats same cycles, FIFO count 1; 2-beat response → req_resp_v_o[0] for 2 beats, req_resp_v_o[1]=0, count 0.
- Tie: both v in IDLE after reset → req0 granted, then req1, then req0 (alternation over 6 single-beat packets); with FIXED_PRIO_EN, req0 wins all while valid.
- Lock: req0 mid-packet with mem_cmd_ready_and_i toggling 1/0, req1 valid throughout → req1 ready_and stays 0 until req0 last beat accepted.
- Full: max_outstanding_p=4, 4 packets accepted, no response → 5th command sees ready_and=0; one response packet completes → 5th accepted cycle after pop.
- Ordering: issue req1, req0, req1 packets; responses in order with req_resp_ready_and_i[0] held 0 for 5 cycles → response stream stalls (mem_resp_ready_and_o=0), delivered to 1,0,1 exactly.
- Reset mid-packet: assert reset_i=0 during LOCK1 → next cycle all v/ready outputs 0; after release, req0 tie-win and FIFO empty (stray mem_resp_v_i not accepted).

Source files
------------

// File: rtl/bp_me_mem_stream_arbiter_if.sv
// rtl/bp_me_mem_stream_arbiter_if.sv - BedRock stream bundle between two requesters and one memory port
interface bp_me_mem_stream_arbiter_if
  #(parameter int header_width_p = 64
   ,parameter int data_width_p   = 64
   );

  logic [1:0][header_width_p-1:0] req_cmd_header_i;
  logic [1:0][data_width_p-1:0]   req_cmd_data_i;
  logic [1:0]                     req_cmd_v_i;
  logic [1:0]                     req_cmd_ready_and_o;
  logic [1:0]                     req_cmd_last_i;

  logic [1:0][header_width_p-1:0] req_resp_header_o;
  logic [1:0][data_width_p-1:0]   req_resp_data_o;
  logic [1:0]                     req_resp_v_o;
  logic [1:0]                     req_resp_ready_and_i;
  logic [1:0]                     req_resp_last_o;

  logic [header_width_p-1:0]      mem_cmd_header_o;
  logic [data_width_p-1:0]        mem_cmd_data_o;
  logic                           mem_cmd_v_o;
  logic                           mem_cmd_ready_and_i;
  logic                           mem_cmd_last_o;

  logic [header_width_p-1:0]      mem_resp_header_i;
  logic [data_width_p-1:0]        mem_resp_data_i;
  logic                           mem_resp_v_i;
  logic                           mem_resp_ready_and_o;
  logic                           mem_resp_last_i;

  // Environment side: requesters plus memory
  modport master
    (output req_cmd_header_i, req_cmd_data_i, req_cmd_v_i, req_cmd_last_i
    ,input  req_cmd_ready_and_o
    ,input  req_resp_header_o, req_resp_data_o, req_resp_v_o, req_resp_last_o
    ,output req_resp_ready_and_i
    ,input  mem_cmd_header_o, mem_cmd_data_o, mem_cmd_v_o, mem_cmd_last_o
    ,output mem_cmd_ready_and_i
    ,output mem_resp_header_i, mem_resp_data_i, mem_resp_v_i, mem_resp_last_i
    ,input  mem_resp_ready_and_o
    );

  // Arbiter side
  modport slave
    (input  req_cmd_header_i, req_cmd_data_i, req_cmd_v_i, req_cmd_last_i
    ,output req_cmd_ready_and_o
    ,output req_resp_header_o, req_resp_data_o, req_resp_v_o, req_resp_last_o
    ,input  req_resp_ready_and_i
    ,output mem_cmd_header_o, mem_cmd_data_o, mem_cmd_v_o, mem_cmd_last_o
    ,input  mem_cmd_ready_and_i
    ,input  mem_resp_header_i, mem_resp_data_i, mem_resp_v_i, mem_resp_last_i
    ,output mem_resp_ready_and_o
    );

endinterface

// File: rtl/bp_me_mem_stream_arbiter.sv
// rtl/bp_me_mem_stream_arbiter.sv - two-requester whole-packet round-robin arbiter onto one BedRock stream memory port
// BP_ME_MEM_ARB_FIXED_PRIO_EN: when defined, ties always go to requester 0.
module bp_me_mem_stream_arbiter
  #(parameter int header_width_p    = 64
   ,parameter int data_width_p      = 64
   ,parameter int max_outstanding_p = 4
   )
  (input logic                      clk_i
  ,input logic                      reset_i
  ,bp_me_mem_stream_arbiter_if.slave bus
  );

  localparam int cnt_w_lp = $clog2(max_outstanding_p+1);
  localparam int ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(max_outstanding_p);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(max_outstanding_p-1);

  typedef enum logic [1:0] {e_idle, e_lock0, e_lock1} state_e;

  state_e                       state_r, state_n;
  logic                         rr_last_r;
  logic [max_outstanding_p-1:0] id_mem_r;
  logic [ptr_w_lp-1:0]          wptr_r, rptr_r;
  logic [cnt_w_lp-1:0]          count_r;

  logic                         fifo_full, fifo_empty, head_id;
  logic [1:0]                   cand;
  logic                         cmd_sel, cmd_grant, cmd_fire, push, pop;
  logic [header_width_p-1:0]    cmd_header_sel;
  logic [data_width_p-1:0]      cmd_data_sel;

  assign fifo_full  = (count_r == full_cnt_lp);
  assign fifo_empty = (count_r == '0);
  assign head_id    = id_mem_r[rptr_r];

  always_comb begin
    state_n   = state_r;
    cand      = '0;
    cmd_sel   = 1'b0;
    cmd_grant = 1'b0;
    case (state_r)
      e_lock0: begin
        cmd_grant = 1'b1;
        cmd_sel   = 1'b0;
      end
      e_lock1: begin
        cmd_grant = 1'b1;
        cmd_sel   = 1'b1;
      end
      default: begin
        // Full check uses the registered count, so a same-cycle pop never frees a slot
        cand      = bus.req_cmd_v_i & {2{~fifo_full}};
        cmd_grant = |cand;
`ifdef BP_ME_MEM_ARB_FIXED_PRIO_EN
        cmd_sel   = ~cand[0];
`else
        cmd_sel   = (&cand) ? ~rr_last_r : cand[1];
`endif
      end
    endcase
    cmd_fire = reset_i & cmd_grant & bus.req_cmd_v_i[cmd_sel] & bus.mem_cmd_ready_and_i;
    if (cmd_fire && bus.req_cmd_last_i[cmd_sel])
      state_n = e_idle;
    else if (cmd_fire && (state_r == e_idle))
      state_n = cmd_sel ? e_lock1 : e_lock0;
  end

  assign push = cmd_fire & (state_r == e_idle);
  assign pop  = bus.mem_resp_v_i & bus.mem_resp_ready_and_o & bus.mem_resp_last_i;

  assign cmd_header_sel       = bus.req_cmd_header_i[cmd_sel];
  assign cmd_data_sel         = bus.req_cmd_data_i[cmd_sel];
  assign bus.mem_cmd_header_o = cmd_header_sel;
  assign bus.mem_cmd_data_o   = cmd_data_sel;
  assign bus.mem_cmd_last_o   = bus.req_cmd_last_i[cmd_sel];
  assign bus.mem_cmd_v_o      = reset_i & cmd_grant & bus.req_cmd_v_i[cmd_sel];

  always_comb begin
    bus.req_cmd_ready_and_o          = '0;
    bus.req_cmd_ready_and_o[cmd_sel] = reset_i & cmd_grant & bus.mem_cmd_ready_and_i;
  end

  // Responses come back in command order; only valid is steered, payload fans out
  assign bus.req_resp_header_o    = {2{bus.mem_resp_header_i}};
  assign bus.req_resp_data_o      = {2{bus.mem_resp_data_i}};
  assign bus.req_resp_last_o      = {2{bus.mem_resp_last_i}};
  assign bus.mem_resp_ready_and_o = reset_i & ~fifo_empty & bus.req_resp_ready_and_i[head_id];

  always_comb begin
    bus.req_resp_v_o          = '0;
    bus.req_resp_v_o[head_id] = reset_i & ~fifo_empty & bus.mem_resp_v_i;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r   <= e_idle;
      rr_last_r <= 1'b1;
      id_mem_r  <= '0;
      wptr_r    <= '0;
      rptr_r    <= '0;
      count_r   <= '0;
    end else begin
      state_r <= state_n;
      if (push) begin
        id_mem_r[wptr_r] <= cmd_sel;
        wptr_r           <= (wptr_r == last_ptr_lp) ? '0 : wptr_r + ptr_w_lp'(1);
        rr_last_r        <= cmd_sel;
      end
      if (pop)
        rptr_r <= (rptr_r == last_ptr_lp) ? '0 : rptr_r + ptr_w_lp'(1);
      count_r <= count_r + cnt_w_lp'(push) - cnt_w_lp'(pop);
    end
  end

endmodule

// File: tb/tb_bp_me_mem_stream_arbiter.sv
// tb/tb_bp_me_mem_stream_arbiter.sv - vector table, corner sequences and randomized model check of the stream arbiter
`timescale 1ns/1ps
module tb_bp_me_mem_stream_arbiter;

  localparam int hw_lp = 64;
  localparam int dw_lp = 64;
  localparam int mo_lp = 4;
  localparam logic [63:0] h0_lp = 64'hA0A0_0000_0000_0001;
  localparam logic [63:0] h1_lp = 64'hB1B1_0000_0000_0002;
  localparam logic [63:0] d0_lp = 64'hD0D0_1111_2222_3333;
  localparam logic [63:0] d1_lp = 64'hD1D1_4444_5555_6666;
`ifdef BP_ME_MEM_ARB_FIXED_PRIO_EN
  localparam bit fixed_prio_lp = 1'b1;
`else
  localparam bit fixed_prio_lp = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk_i = ~clk_i;

  bp_me_mem_stream_arbiter_if #(.header_width_p(hw_lp), .data_width_p(dw_lp)) bus();

  bp_me_mem_stream_arbiter #(.header_width_p(hw_lp), .data_width_p(dw_lp), .max_outstanding_p(mo_lp)) dut
    (.clk_i(clk_i), .reset_i(reset_i), .bus(bus));

  typedef struct {
    logic [1:0] cv, cl;
    logic       mcr, rv, rl;
    logic [1:0] rr;
    logic [1:0] e_crdy;
    logic       e_mcv, e_sel;
    logic [1:0] e_rv;
    logic       e_mrr;
  } vec_t;

  vec_t tbl [0:21];
  int   ord [0:3];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [1:0] cv, input logic [1:0] cl, input logic mcr, input logic rv,
                              input logic rl, input logic [1:0] rr, input logic [1:0] ecr, input logic emcv,
                              input logic esel, input logic [1:0] erv, input logic emrr);
    vec_t v;
    v.cv = cv; v.cl = cl; v.mcr = mcr; v.rv = rv; v.rl = rl; v.rr = rr;
    v.e_crdy = ecr; v.e_mcv = emcv; v.e_sel = esel; v.e_rv = erv; v.e_mrr = emrr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] cv, input logic [1:0] cl, input logic mcr, input logic rv,
                       input logic rl, input logic [1:0] rr);
    bus.req_cmd_v_i          = cv;
    bus.req_cmd_last_i       = cl;
    bus.mem_cmd_ready_and_i  = mcr;
    bus.mem_resp_v_i         = rv;
    bus.mem_resp_last_i      = rl;
    bus.req_resp_ready_and_i = rr;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] crdy, input logic mcv,
                            input logic [1:0] rv, input logic mrr);
    chk({tag, "_cmd_ready"}, 64'(bus.req_cmd_ready_and_o), 64'(crdy));
    chk({tag, "_mem_cmd_v"}, 64'(bus.mem_cmd_v_o), 64'(mcv));
    chk({tag, "_resp_v"}, 64'(bus.req_resp_v_o), 64'(rv));
    chk({tag, "_mem_resp_ready"}, 64'(bus.mem_resp_ready_and_o), 64'(mrr));
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  logic [1:0]  cv, cl, rr, e_crdy, e_rv, c;
  logic        mcr, rv, rl, e_mcv, e_mrr;
  logic [63:0] rh [0:1];
  logic [63:0] rd [0:1];
  int          q [$];
  int          owner, lastw, w, h, qsz;
  bit          g;

  initial begin
    tbl[0]  = mk(2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0);
    tbl[1]  = mk(2'b01, 2'b00, 1, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 0);
    tbl[2]  = mk(2'b01, 2'b01, 1, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 0);
    tbl[3]  = mk(2'b00, 2'b00, 0, 1, 0, 2'b01, 2'b00, 0, 0, 2'b01, 1);
    tbl[4]  = mk(2'b00, 2'b00, 0, 1, 1, 2'b01, 2'b00, 0, 0, 2'b01, 1);
    tbl[5]  = mk(2'b00, 2'b00, 0, 1, 1, 2'b11, 2'b00, 0, 0, 2'b00, 0);
    tbl[6]  = mk(2'b11, 2'b11, 1, 0, 0, 2'b00, 2'b10, 1, 1, 2'b00, 0);
    tbl[7]  = mk(2'b11, 2'b11, 1, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 0);
    tbl[8]  = mk(2'b11, 2'b11, 1, 0, 0, 2'b00, 2'b10, 1, 1, 2'b00, 0);
    tbl[9]  = mk(2'b11, 2'b11, 1, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 0);
    tbl[10] = mk(2'b11, 2'b11, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0);
    tbl[11] = mk(2'b11, 2'b11, 1, 1, 1, 2'b11, 2'b00, 0, 0, 2'b10, 1);
    tbl[12] = mk(2'b11, 2'b11, 1, 0, 0, 2'b00, 2'b10, 1, 1, 2'b00, 0);
    tbl[13] = mk(2'b00, 2'b00, 0, 1, 1, 2'b01, 2'b00, 0, 0, 2'b01, 1);
    tbl[14] = mk(2'b00, 2'b00, 0, 1, 1, 2'b10, 2'b00, 0, 0, 2'b10, 1);
    tbl[15] = mk(2'b00, 2'b00, 0, 1, 1, 2'b10, 2'b00, 0, 0, 2'b01, 0);
    tbl[16] = mk(2'b11, 2'b00, 1, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 0);
    tbl[17] = mk(2'b11, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 0);
    tbl[18] = mk(2'b11, 2'b01, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 0);
    tbl[19] = mk(2'b11, 2'b01, 1, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 0);
    tbl[20] = mk(2'b11, 2'b11, 1, 0, 0, 2'b00, 2'b10, 1, 1, 2'b00, 0);
    tbl[21] = mk(2'b11, 2'b11, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0);
    ord[0] = 0; ord[1] = 1; ord[2] = 0; ord[3] = 1;

    bus.req_cmd_header_i[0] = h0_lp;
    bus.req_cmd_header_i[1] = h1_lp;
    bus.req_cmd_data_i[0]   = d0_lp;
    bus.req_cmd_data_i[1]   = d1_lp;
    bus.mem_resp_header_i   = 64'h5EED_0000_CAFE_0001;
    bus.mem_resp_data_i     = 64'h5EED_0000_BEEF_0002;
    drive(2'b11, 2'b11, 1, 1, 1, 2'b11);
    #1;
    expect_out("in_reset", 2'b00, 0, 2'b00, 0);
    tick;
    tick;
    reset_i = 1'b1;

`ifndef BP_ME_MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].cv, tbl[i].cl, tbl[i].mcr, tbl[i].rv, tbl[i].rl, tbl[i].rr);
      #2;
      expect_out($sformatf("vec%0d", i), tbl[i].e_crdy, tbl[i].e_mcv, tbl[i].e_rv, tbl[i].e_mrr);
      if (tbl[i].e_mcv) begin
        chk($sformatf("vec%0d_hdr", i), bus.mem_cmd_header_o, tbl[i].e_sel ? h1_lp : h0_lp);
        chk($sformatf("vec%0d_data", i), bus.mem_cmd_data_o, tbl[i].e_sel ? d1_lp : d0_lp);
        chk($sformatf("vec%0d_last", i), 64'(bus.mem_cmd_last_o), 64'(tbl[i].cl[tbl[i].e_sel]));
      end
      tick;
    end

    // Outstanding order is 0,1,0,1; requester 0 holds off for five cycles first
    for (int i = 0; i < 5; i++) begin
      drive(2'b00, 2'b00, 0, 1, 1, 2'b10);
      #2;
      expect_out($sformatf("stall%0d", i), 2'b00, 0, 2'b01, 0);
      tick;
    end
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, 2'b00, 0, 1, 1, 2'b11);
      #2;
      expect_out($sformatf("order%0d", i), 2'b00, 0, (ord[i] == 1) ? 2'b10 : 2'b01, 1);
      tick;
    end
    #2;
    expect_out("drained", 2'b00, 0, 2'b00, 0);
    tick;
`endif

    // Randomized run against a queue-based model
    reset_i = 1'b0;
    tick;
    reset_i = 1'b1;
    q.delete();
    owner = -1;
    lastw = 1;
    for (int n = 0; n < 3000; n++) begin
      cv  = 2'($urandom_range(0, 3));
      cl  = 2'($urandom_range(0, 3));
      mcr = ($urandom_range(0, 3) != 0);
      rv  = 1'($urandom_range(0, 1));
      rl  = 1'($urandom_range(0, 1));
      rr  = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        rh[k] = {$urandom, $urandom};
        rd[k] = {$urandom, $urandom};
        bus.req_cmd_header_i[k] = rh[k];
        bus.req_cmd_data_i[k]   = rd[k];
      end
      bus.mem_resp_header_i = {$urandom, $urandom};
      bus.mem_resp_data_i   = {$urandom, $urandom};
      drive(cv, cl, mcr, rv, rl, rr);

      qsz = q.size();
      if (owner >= 0) begin
        g = 1'b1;
        w = owner;
      end else begin
        c = (qsz < mo_lp) ? cv : 2'b00;
        g = (c != 2'b00);
        if (c == 2'b11) w = fixed_prio_lp ? 0 : 1 - lastw;
        else            w = c[1] ? 1 : 0;
      end
      e_mcv     = g & cv[w];
      e_crdy    = 2'b00;
      e_crdy[w] = g & mcr;
      e_rv      = 2'b00;
      e_mrr     = 1'b0;
      h         = (qsz > 0) ? q[0] : 0;
      if (qsz > 0) begin
        e_rv[h] = rv;
        e_mrr   = rr[h];
      end

      #2;
      expect_out($sformatf("rnd%0d", n), e_crdy, e_mcv, e_rv, e_mrr);
      if (e_mcv) begin
        chk($sformatf("rnd%0d_hdr", n), bus.mem_cmd_header_o, rh[w]);
        chk($sformatf("rnd%0d_data", n), bus.mem_cmd_data_o, rd[w]);
      end
      chk($sformatf("rnd%0d_resp_hdr", n), bus.req_resp_header_o[n % 2], bus.mem_resp_header_i);

      if (qsz > 0 && rv && rr[h] && rl) void'(q.pop_front());
      if (e_mcv && mcr) begin
        if (owner < 0) begin
          q.push_back(w);
          lastw = w;
          owner = cl[w] ? -1 : w;
        end else if (cl[w]) begin
          owner = -1;
        end
      end
      tick;
    end

    // Reset dropped in the middle of a requester-1 packet
    reset_i = 1'b0;
    tick;
    reset_i = 1'b1;
    bus.req_cmd_header_i[0] = h0_lp;
    bus.req_cmd_header_i[1] = h1_lp;
    drive(2'b10, 2'b00, 1, 0, 0, 2'b00);
    #2;
    expect_out("lock1_first", 2'b10, 1, 2'b00, 0);
    tick;
    drive(2'b11, 2'b11, 1, 1, 1, 2'b11);
    #2;
    expect_out("lock1_mid", 2'b10, 1, 2'b10, 1);
    chk("lock1_mid_hdr", bus.mem_cmd_header_o, h1_lp);
    reset_i = 1'b0;
    #1;
    expect_out("mid_reset", 2'b00, 0, 2'b00, 0);
    tick;
    expect_out("held_reset", 2'b00, 0, 2'b00, 0);
    reset_i = 1'b1;
    #2;
    expect_out("post_reset", 2'b01, 1, 2'b00, 0);
    chk("post_reset_hdr", bus.mem_cmd_header_o, h0_lp);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
